or_merge_pipe: RTL

Parametrised successor to the fixed two-register OR/AND datapath. Moves a WIDTH-bit word through DEPTH register stages and ORs a per-stage side lane into the word as it enters each stage. Adds a valid/ready handshake with bubble collapsing, backpressure, and an occupancy count. Sits between a producer of partial flag words and a consumer that needs the merged result.

---
 rtl/or_merge_pkg.sv | 19 +
 rtl/or_merge_stage.sv | 48 ++++
 rtl/or_merge_pipe.sv | 97 +++++++++
 3 files changed

// File: rtl/or_merge_pkg.sv
// Shared constants and types for the OR-merge pipeline.
// Stage record layout, default geometry and occupancy width helper.
package or_merge_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_DEPTH = 2;

  // Occupancy counts 0..DEPTH inclusive, hence DEPTH+1 codes.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Default-width record; stages declare the same layout at their own WIDTH.
  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH-1:0] dat;
  } stage_t;

endpackage

// File: rtl/or_merge_stage.sv
// One pipeline stage: valid/data register, OR merge of the side lane on load.
// Latency: 1 cycle from load to registered output.
// Backpressure: holds its word unless it advances or is overwritten by a load.
module or_merge_stage
  import or_merge_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] up_dat,
  input  logic [WIDTH-1:0] side_dat,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             vld_nxt
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dat;
  } stage_rec_t;

  stage_rec_t q;

  // A load wins over an advance: the slot is refilled as its word leaves.
  always_comb begin
    vld_nxt = q.vld;
    if (clr)       vld_nxt = 1'b0;
    else if (load) vld_nxt = 1'b1;
    else if (adv)  vld_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q.vld <= vld_nxt;
      if (load && !clr) q.dat <= up_dat | side_dat;
    end
  end

  assign vld = q.vld;
  assign dat = q.dat;

endmodule

// File: rtl/or_merge_pipe.sv
// DEPTH-stage pipeline ORing a per-stage side lane into each word; optional flush via OR_MERGE_PIPE_FLUSH_EN.
// Latency: DEPTH cycles from acceptance to out_valid; 1 word/cycle sustained.
// Backpressure: bubbles collapse; out_ready ripples combinationally to in_ready.
module or_merge_pipe
  import or_merge_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [DEPTH*WIDTH-1:0] side_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [OCC_W-1:0]       occupancy
`ifdef OR_MERGE_PIPE_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d [DEPTH];
  logic [OCC_W-1:0] occ_nxt;
  logic             flush_act;

`ifdef OR_MERGE_PIPE_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Ready chain resolved tail-first so each stage sees its successor's advance.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v[DEPTH-1] & out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = v[k] & (~v[k+1] | adv[k+1]);
    end
  end

  assign in_ready = (~v[0] | adv[0]) & ~flush_act;

  always_comb begin
    load = '0;
    load[0] = in_valid & in_ready;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] up_dat;
    if (k == 0) begin : g_head
      assign up_dat = in_data;
    end else begin : g_body
      assign up_dat = d[k-1];
    end

    or_merge_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush_act),
      .load     (load[k]),
      .adv      (adv[k]),
      .up_dat   (up_dat),
      .side_dat (side_data[k*WIDTH +: WIDTH]),
      .vld      (v[k]),
      .dat      (d[k]),
      .vld_nxt  (v_nxt[k])
    );
  end

  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_nxt = occ_nxt + OCC_W'(v_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occupancy <= '0;
    else     occupancy <= occ_nxt;
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule
